imem_loader: RTL and testbench

- Byte-stream program loader: the write-side counterpart to the byte-addressed, little-endian, 32-bit instruction memory.
- Accepts a framed byte stream over a valid/ready handshake (header, payload, XOR trailer).
- Assembles payload bytes into little-endian 32-bit words and drives a word-wide write port with byte enables into the instruction RAM.
- Holds the CPU (cpu_hold) for the whole load; sits between the host/UART byte source and the writable instruction memory.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_word_packer.sv | 75 +++++++
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  // Loader control states.
  typedef enum logic [2:0] {
    IDLE,
    HDR_ADDR,
    HDR_LEN,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int unsigned HDR_BYTES      = 4;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int unsigned HDR_CNT_W      = $clog2(HDR_BYTES);

endpackage

// File: rtl/imem_word_packer.sv
// Packs payload bytes into little-endian words and issues one registered
// write per completed (or final partial) word.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           drop any partially assembled word
//   valid           data holds an accepted payload byte
//   last            this byte is the final payload byte
//   lane            byte lane of this byte within its word
//   data            payload byte
//   addr            word-aligned byte address of the word being built
//   we/waddr/wdata/be  registered write port, we pulses for one cycle
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      valid,
  input  logic                      last,
  input  logic [LANE_W-1:0]         lane,
  input  logic [7:0]                data,
  input  logic [ADDR_WIDTH-1:0]     addr,
  output logic                      we,
  output logic [ADDR_WIDTH-1:0]     waddr,
  output logic [WIDTH-1:0]          wdata,
  output logic [BYTES_PER_WORD-1:0] be
);

  logic [WIDTH-1:0]          word_q;
  logic [WIDTH-1:0]          word_c;
  logic [BYTES_PER_WORD-1:0] be_q;
  logic [BYTES_PER_WORD-1:0] be_c;

  // Current buffer with the incoming byte merged into its lane.
  always_comb begin
    word_c = word_q;
    be_c   = be_q;
    word_c[{lane, 3'b000} +: 8] = data;
    be_c[lane] = 1'b1;
  end

  // Buffer accumulation and one-deep write stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      be_q   <= '0;
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
      be     <= '0;
    end else begin
      we <= 1'b0;
      if (clear) begin
        word_q <= '0;
        be_q   <= '0;
      end else if (valid) begin
        if (last || (lane == LANE_W'(BYTES_PER_WORD - 1))) begin
          we     <= 1'b1;
          waddr  <= addr;
          wdata  <= word_c;
          be     <= be_c;
          word_q <= '0;
          be_q   <= '0;
        end else begin
          word_q <= word_c;
          be_q   <= be_c;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the writable instruction memory.
// Frame: 4-byte LE base, 4-byte LE length, payload, XOR checksum byte.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a load (honoured in IDLE, DONE, ERROR)
//   in_valid/in_data      byte stream input, in_ready accepts
//   mem_we/addr/wdata/be  word write port to instruction RAM
//   cpu_hold              CPU stall while a load is in progress
//   done/error            sticky load status
//   bytes_loaded          payload bytes accepted in the current load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [WIDTH-1:0]          mem_wdata,
  output logic [BYTES_PER_WORD-1:0] mem_be,
  output logic                      cpu_hold,
  output logic                      done,
  output logic                      error,
  output logic [ADDR_WIDTH:0]       bytes_loaded
);

  localparam int unsigned SUM_W = ADDR_WIDTH + 33;
  localparam int unsigned LEN_W = ADDR_WIDTH + 1;

  state_t                state_q;
  state_t                state_d;
  logic [HDR_CNT_W-1:0]  hdr_cnt_q;
  logic [31:0]           base_q;
  logic [31:0]           len_q;
  logic [7:0]            csum_q;

  logic                  accept_c;
  logic                  restart_c;
  logic                  hdr_last_c;
  logic                  pay_last_c;
  logic [31:0]           len_full_c;
  logic [SUM_W-1:0]      end_c;
  logic                  over_c;
  logic [ADDR_WIDTH-1:0] byte_addr_c;
  logic [ADDR_WIDTH-1:0] word_addr_c;

  assign accept_c   = in_valid && in_ready;
  assign hdr_last_c = (hdr_cnt_q == HDR_CNT_W'(HDR_BYTES - 1));
  assign len_full_c = {in_data, len_q[31:8]};
  // Bounds check on the completed length, wide enough that nothing wraps.
  assign end_c      = SUM_W'(base_q) + SUM_W'(len_full_c);
  assign over_c     = end_c > (SUM_W'(1) << ADDR_WIDTH);
  // Length was bounds-checked, so it fits in LEN_W bits here.
  assign pay_last_c = ((bytes_loaded + LEN_W'(1)) == LEN_W'(len_q));
  assign byte_addr_c = base_q[ADDR_WIDTH-1:0] + bytes_loaded[ADDR_WIDTH-1:0];
  assign word_addr_c = {byte_addr_c[ADDR_WIDTH-1:LANE_W], LANE_W'(0)};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    restart_c = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d   = HDR_ADDR;
          restart_c = 1'b1;
        end
      end
      HDR_ADDR: if (accept_c && hdr_last_c) state_d = HDR_LEN;
      HDR_LEN: begin
        if (accept_c && hdr_last_c) begin
          if ((base_q[1:0] != 2'b00) || over_c) state_d = ERROR;
          else if (len_full_c == 32'd0)         state_d = CHECK;
          else                                  state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (accept_c && pay_last_c) state_d = CHECK;
      CHECK: begin
        if (accept_c) state_d = (in_data == csum_q) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Header capture, checksum, byte count and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_cnt_q    <= '0;
      base_q       <= '0;
      len_q        <= '0;
      csum_q       <= '0;
      bytes_loaded <= '0;
      in_ready     <= 1'b0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      in_ready <= state_d inside {HDR_ADDR, HDR_LEN, PAYLOAD, CHECK};
      cpu_hold <= state_d inside {HDR_ADDR, HDR_LEN, PAYLOAD, CHECK};
      done     <= (state_d == DONE);
      error    <= (state_d == ERROR);
      if (restart_c) begin
        hdr_cnt_q    <= '0;
        base_q       <= '0;
        len_q        <= '0;
        csum_q       <= '0;
        bytes_loaded <= '0;
      end else if (accept_c) begin
        case (state_q)
          HDR_ADDR: begin
            base_q    <= {in_data, base_q[31:8]};
            hdr_cnt_q <= hdr_cnt_q + HDR_CNT_W'(1);
          end
          HDR_LEN: begin
            len_q     <= len_full_c;
            hdr_cnt_q <= hdr_cnt_q + HDR_CNT_W'(1);
          end
          PAYLOAD: begin
            csum_q       <= csum_q ^ in_data;
            bytes_loaded <= bytes_loaded + LEN_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  imem_word_packer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WIDTH     (WIDTH)
  ) u_packer (
    .clk  (clk),
    .rst  (rst),
    .clear(restart_c),
    .valid(accept_c && (state_q == PAYLOAD)),
    .last (pay_last_c),
    .lane (bytes_loaded[LANE_W-1:0]),
    .data (in_data),
    .addr (word_addr_c),
    .we   (mem_we),
    .waddr(mem_addr),
    .wdata(mem_wdata),
    .be   (mem_be)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader.
module tb_imem_loader;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   bytes_loaded;

  imem_loader #(.ADDR_WIDTH(AW), .WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error),
    .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int          c;
  } wr_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] len;
    logic [63:0] pay;      // payload byte i at [8i+7:8i]
    logic [7:0]  trailer;
    bit          body;     // 0: header is expected to be rejected
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
    int          nwr;
    logic [31:0] waddr;    // write i address at [16i+15:16i]
    logic [63:0] wdata;    // write i data at [32i+31:32i]
    logic [7:0]  wbe;      // write i enables at [4i+3:4i]
  } vec_t;

  wr_t  wlog[$];
  int   ecyc[$];
  vec_t tab[8];

  int vectors = 0;
  int miscompares = 0;

  // Write-port monitor.
  always @(negedge clk) begin
    if (mem_we) wlog.push_back('{mem_addr, mem_wdata, mem_be, cyc});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit completes);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    if (completes) ecyc.push_back(cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] base, input logic [31:0] len, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(base[8*i +: 8], gaps, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], gaps, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    wlog.delete();
    ecyc.delete();
    do_start();
    send_header(v.base, v.len, v.gaps);
    if (!v.body) begin
      chk($sformatf("v%0d hdr_error_now", idx), 64'(error), 64'(1));
    end else begin
      n = int'(v.len);
      for (int i = 0; i < n; i++)
        send_byte(v.pay[8*i +: 8], v.gaps, (i % 4 == 3) || (i == n - 1));
      send_byte(v.trailer, v.gaps, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d done", idx), 64'(done), 64'(v.exp_done));
    chk($sformatf("v%0d error", idx), 64'(error), 64'(v.exp_err));
    chk($sformatf("v%0d cpu_hold", idx), 64'(cpu_hold), 64'(0));
    chk($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'(0));
    chk($sformatf("v%0d bytes_loaded", idx), 64'(bytes_loaded),
        v.body ? 64'(v.len) : 64'(0));
    chk($sformatf("v%0d nwrites", idx), 64'(wlog.size()), 64'(v.nwr));
    for (int i = 0; i < v.nwr; i++) begin
      if (i < wlog.size()) begin
        chk($sformatf("v%0d w%0d addr", idx, i), 64'(wlog[i].a), 64'(v.waddr[16*i +: 16]));
        chk($sformatf("v%0d w%0d data", idx, i), 64'(wlog[i].d), 64'(v.wdata[32*i +: 32]));
        chk($sformatf("v%0d w%0d be", idx, i), 64'(wlog[i].be), 64'(v.wbe[4*i +: 4]));
        if (i < ecyc.size())
          chk($sformatf("v%0d w%0d latency", idx, i), 64'(wlog[i].c), 64'(ecyc[i]));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Aligned load; checksum = 13^50^93^10 = C0.
    tab[0] = '{base:32'h100, len:32'd8, pay:64'h0010_0093_0050_0013, trailer:8'hC0,
               body:1, gaps:0, exp_done:1, exp_err:0, nwr:2,
               waddr:{16'h0104, 16'h0100}, wdata:{32'h0010_0093, 32'h0050_0013}, wbe:8'hFF};
    // Partial tail word.
    tab[1] = '{base:32'h0, len:32'd6, pay:64'h0000_0605_0403_0201, trailer:8'h07,
               body:1, gaps:0, exp_done:1, exp_err:0, nwr:2,
               waddr:{16'h0004, 16'h0000}, wdata:{32'h0000_0605, 32'h0403_0201}, wbe:8'h3F};
    // Bad checksum: writes still happen.
    tab[2] = tab[0];
    tab[2].trailer = 8'hD1; tab[2].exp_done = 0; tab[2].exp_err = 1;
    // Misaligned base.
    tab[3] = '{base:32'h102, len:32'd8, pay:64'h0, trailer:8'h0,
               body:0, gaps:0, exp_done:0, exp_err:1, nwr:0,
               waddr:32'h0, wdata:64'h0, wbe:8'h0};
    // Runs past the top of memory.
    tab[4] = tab[3];
    tab[4].base = 32'hFFFC;
    // Scenario 1 with random valid gaps.
    tab[5] = tab[0];
    tab[5].gaps = 1;
    // Zero length.
    tab[6] = '{base:32'h40, len:32'd0, pay:64'h0, trailer:8'h00,
               body:1, gaps:0, exp_done:1, exp_err:0, nwr:0,
               waddr:32'h0, wdata:64'h0, wbe:8'h0};
    // Ends exactly at the top of memory.
    tab[7] = tab[0];
    tab[7].base = 32'hFFF8;
    tab[7].waddr = {16'hFFFC, 16'hFFF8};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'(0));
    chk("reset cpu_hold", 64'(cpu_hold), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset error", 64'(error), 64'(0));
    chk("reset mem_we", 64'(mem_we), 64'(0));
    chk("reset bytes_loaded", 64'(bytes_loaded), 64'(0));

    for (int i = 0; i < 8; i++) run_vec(tab[i], i);

    // Bytes offered in DONE are not consumed.
    wlog.delete();
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) @(negedge clk);
    chk("done in_ready", 64'(in_ready), 64'(0));
    chk("done stays", 64'(done), 64'(1));
    chk("done bytes_loaded", 64'(bytes_loaded), 64'(8));
    in_valid = 1'b0;
    chk("done no write", 64'(wlog.size()), 64'(0));

    // Start mid-payload is ignored; reset mid-payload discards the partial word.
    wlog.delete();
    ecyc.delete();
    do_start();
    chk("restart clears done", 64'(done), 64'(0));
    chk("restart cpu_hold", 64'(cpu_hold), 64'(1));
    send_header(32'h200, 32'd8, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    start = 1'b1;
    send_byte(8'hBB, 1'b0, 1'b0);
    start = 1'b0;
    send_byte(8'hCC, 1'b0, 1'b0);
    chk("mid start ignored", 64'(bytes_loaded), 64'(3));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst in_ready", 64'(in_ready), 64'(0));
    chk("midrst cpu_hold", 64'(cpu_hold), 64'(0));
    chk("midrst done", 64'(done), 64'(0));
    chk("midrst error", 64'(error), 64'(0));
    chk("midrst mem_we", 64'(mem_we), 64'(0));
    chk("midrst mem_addr", 64'(mem_addr), 64'(0));
    chk("midrst mem_wdata", 64'(mem_wdata), 64'(0));
    chk("midrst mem_be", 64'(mem_be), 64'(0));
    chk("midrst bytes_loaded", 64'(bytes_loaded), 64'(0));
    repeat (3) @(negedge clk);
    chk("midrst no write", 64'(wlog.size()), 64'(0));
    run_vec(tab[0], 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
